operand_fetch: RTL and testbench

Decode/operand-fetch stage of the 16-bit Harvard processor. Accepts one instruction per cycle from the fetch stage and splits it into fields. Drives the register-file read ports, and registers the decoded operation and its operands into the ID/EX pipeline register feeding execute. A 32-entry scoreboard blocks RAW and WAW hazards against in-flight writes, and same-cycle writeback data is bypassed around the register file.

---
 rtl/proc_pkg.sv | 50 +++++
 rtl/operand_fetch_scoreboard.sv | 36 +++
 rtl/operand_fetch.sv | 102 ++++++++++
 tb/tb_operand_fetch.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared widths, instruction field layout and opcode class helpers
package proc_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int OPC_W  = 6;
  localparam int IMM_W  = 5;
  localparam int NREG   = 1 << ADDR_W;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 10;
  localparam int RD_MSB  = 9;
  localparam int RD_LSB  = 5;
  localparam int RS2_MSB = 4;
  localparam int RS2_LSB = 0;

  localparam logic [OPC_W-1:0] OPC_NOP        = 6'h00;
  localparam logic [OPC_W-1:0] OPC_IMM_MASK   = 6'b100000;
  localparam logic [OPC_W-1:0] OPC_STORE_MASK = 6'b110000;

  typedef struct packed {
    logic              valid;
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] dest;
    logic              wb_en;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
  } id_ex_t;

  function automatic logic opc_is_nop(input logic [OPC_W-1:0] opc);
    return opc == OPC_NOP;
  endfunction

  function automatic logic opc_is_imm(input logic [OPC_W-1:0] opc);
    return (opc & OPC_IMM_MASK) == OPC_IMM_MASK;
  endfunction

  function automatic logic opc_is_store(input logic [OPC_W-1:0] opc);
    return (opc & OPC_STORE_MASK) == OPC_STORE_MASK;
  endfunction

  function automatic logic opc_writes_reg(input logic [OPC_W-1:0] opc);
    return !opc_is_nop(opc) && !opc_is_store(opc);
  endfunction

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// rtl/operand_fetch_scoreboard.sv - per-register busy bits with writeback-bypassed lookup
module operand_fetch_scoreboard
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic [ADDR_W-1:0] look_idx_a,
  input  logic [ADDR_W-1:0] look_idx_b,
  output logic              busy_a,
  output logic              busy_b
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Set is applied after clear so a new writer keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // A write landing this cycle already frees the register for its readers.
  assign busy_a = busy_q[look_idx_a] && !(clr_en && (clr_idx == look_idx_a));
  assign busy_b = busy_q[look_idx_b] && !(clr_en && (clr_idx == look_idx_b));

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - decode, hazard stall, operand bypass and ID/EX register
module operand_fetch
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_instr,
  output logic              if_ready,
  output logic [ADDR_W-1:0] rf_rd_addr1,
  output logic [ADDR_W-1:0] rf_rd_addr2,
  input  logic [DATA_W-1:0] rf_rd_data1,
  input  logic [DATA_W-1:0] rf_rd_data2,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OPC_W-1:0]  ex_opcode,
  output logic [ADDR_W-1:0] ex_dest,
  output logic              ex_wb_en,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b
);

  logic [OPC_W-1:0]  dec_opc;
  logic [ADDR_W-1:0] dec_rd;
  logic [ADDR_W-1:0] dec_rs2;
  logic              dec_nop;
  logic              dec_imm;
  logic              dec_wb_en;
  logic              busy_rd;
  logic              busy_rs2;
  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  id_ex_t            ex_q;
  id_ex_t            ex_d;

  assign dec_opc   = if_instr[OPC_MSB:OPC_LSB];
  assign dec_rd    = if_instr[RD_MSB:RD_LSB];
  assign dec_rs2   = if_instr[RS2_MSB:RS2_LSB];
  assign dec_nop   = opc_is_nop(dec_opc);
  assign dec_imm   = opc_is_imm(dec_opc);
  assign dec_wb_en = opc_writes_reg(dec_opc);

  assign rf_rd_addr1 = dec_rd;
  assign rf_rd_addr2 = dec_rs2;

  operand_fetch_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (accept && dec_wb_en),
    .set_idx    (dec_rd),
    .clr_en     (wb_en),
    .clr_idx    (wb_dest),
    .look_idx_a (dec_rd),
    .look_idx_b (dec_rs2),
    .busy_a     (busy_rd),
    .busy_b     (busy_rs2)
  );

  // rd is always read as operand A, so that term also covers the WAW case.
  assign hazard   = !dec_nop && (busy_rd || (!dec_imm && busy_rs2) || (dec_wb_en && busy_rd));
  assign if_ready = !hazard && (!ex_q.valid || ex_ready);
  assign accept   = if_valid && if_ready;

  always_comb begin
    opnd_a = (wb_en && (wb_dest == dec_rd)) ? wb_data : rf_rd_data1;
    if (dec_imm)                            opnd_b = sext_imm(dec_rs2);
    else if (wb_en && (wb_dest == dec_rs2)) opnd_b = wb_data;
    else                                    opnd_b = rf_rd_data2;
  end

  always_comb begin
    ex_d = ex_q;
    if (accept) begin
      ex_d.valid  = 1'b1;
      ex_d.opcode = dec_opc;
      ex_d.dest   = dec_rd;
      ex_d.wb_en  = dec_wb_en;
      ex_d.op_a   = opnd_a;
      ex_d.op_b   = opnd_b;
    end else if (ex_ready) begin
      ex_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign ex_valid  = ex_q.valid;
  assign ex_opcode = ex_q.opcode;
  assign ex_dest   = ex_q.dest;
  assign ex_wb_en  = ex_q.wb_en;
  assign ex_op_a   = ex_q.op_a;
  assign ex_op_b   = ex_q.op_b;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [15:0] if_instr;
  logic        if_ready;
  logic [4:0]  rf_rd_addr1;
  logic [4:0]  rf_rd_addr2;
  logic [15:0] rf_rd_data1;
  logic [15:0] rf_rd_data2;
  logic        wb_en;
  logic [4:0]  wb_dest;
  logic [15:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [5:0]  ex_opcode;
  logic [4:0]  ex_dest;
  logic        ex_wb_en;
  logic [15:0] ex_op_a;
  logic [15:0] ex_op_b;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_ready    (if_ready),
    .rf_rd_addr1 (rf_rd_addr1),
    .rf_rd_addr2 (rf_rd_addr2),
    .rf_rd_data1 (rf_rd_data1),
    .rf_rd_data2 (rf_rd_data2),
    .wb_en       (wb_en),
    .wb_dest     (wb_dest),
    .wb_data     (wb_data),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_opcode   (ex_opcode),
    .ex_dest     (ex_dest),
    .ex_wb_en    (ex_wb_en),
    .ex_op_a     (ex_op_a),
    .ex_op_b     (ex_op_b)
  );

  function automatic logic [15:0] mk(input logic [5:0] opc, input logic [4:0] rd, input logic [4:0] rs2);
    return {opc, rd, rs2};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic wb_cycle(input logic [4:0] d);
    wb_en = 1'b1; wb_dest = d; wb_data = 16'h0;
    cyc();
    wb_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = 16'h0;
    rf_rd_data1 = 16'h0; rf_rd_data2 = 16'h0;
    wb_en = 1'b0; wb_dest = 5'd0; wb_data = 16'h0; ex_ready = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1;
    mid();
    check("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("reset_if_ready", {31'd0, if_ready}, 32'd1);
    check("reset_busy", dut.u_scoreboard.busy_q, 32'h0);

    // register ALU op r3 <- r3 op r4
    cyc();
    if_valid = 1'b1; if_instr = mk(6'h01, 5'd3, 5'd4);
    rf_rd_data1 = 16'h0005; rf_rd_data2 = 16'h0004;
    mid();
    check("alu_if_ready", {31'd0, if_ready}, 32'd1);
    check("alu_addr1", {27'd0, rf_rd_addr1}, 32'd3);
    check("alu_addr2", {27'd0, rf_rd_addr2}, 32'd4);
    cyc();
    if_instr = mk(6'h02, 5'd3, 5'd4);
    rf_rd_data1 = 16'hDEAD; rf_rd_data2 = 16'h0009;
    mid();
    check("alu_ex_valid", {31'd0, ex_valid}, 32'd1);
    check("alu_op_a", {16'd0, ex_op_a}, 32'h0005);
    check("alu_op_b", {16'd0, ex_op_b}, 32'h0004);
    check("alu_dest", {27'd0, ex_dest}, 32'd3);
    check("alu_wb_en", {31'd0, ex_wb_en}, 32'd1);
    check("alu_busy", dut.u_scoreboard.busy_q, 32'h8);
    check("raw_stall0", {31'd0, if_ready}, 32'd0);
    cyc();
    mid();
    check("raw_stall1", {31'd0, if_ready}, 32'd0);
    check("raw_ex_drained", {31'd0, ex_valid}, 32'd0);
    cyc();
    wb_en = 1'b1; wb_dest = 5'd3; wb_data = 16'h1234;
    mid();
    check("raw_release", {31'd0, if_ready}, 32'd1);
    cyc();
    wb_en = 1'b0; if_valid = 1'b0;
    mid();
    check("raw_ex_valid", {31'd0, ex_valid}, 32'd1);
    check("raw_bypass_a", {16'd0, ex_op_a}, 32'h1234);
    check("raw_op_b", {16'd0, ex_op_b}, 32'h0009);
    check("raw_opcode", {26'd0, ex_opcode}, 32'h02);
    check("set_wins_busy", dut.u_scoreboard.busy_q, 32'h8);
    cyc();
    wb_cycle(5'd3);
    mid();
    check("clear_busy", dut.u_scoreboard.busy_q, 32'h0);

    // immediate form, negative and positive imm5
    if_valid = 1'b1; if_instr = mk(6'h21, 5'd2, 5'b10000);
    rf_rd_data1 = 16'h0011; rf_rd_data2 = 16'h5555;
    cyc();
    if_instr = mk(6'h21, 5'd7, 5'b01111); rf_rd_data1 = 16'h0022;
    mid();
    check("imm_neg_op_b", {16'd0, ex_op_b}, 32'hFFF0);
    check("imm_neg_op_a", {16'd0, ex_op_a}, 32'h0011);
    check("imm_neg_dest", {27'd0, ex_dest}, 32'd2);
    check("imm_back2back", {31'd0, if_ready}, 32'd1);
    cyc();
    if_valid = 1'b0;
    mid();
    check("imm_pos_op_b", {16'd0, ex_op_b}, 32'h000F);
    check("imm_pos_op_a", {16'd0, ex_op_a}, 32'h0022);
    check("imm_busy", dut.u_scoreboard.busy_q, 32'h84);
    cyc();
    wb_cycle(5'd2);
    wb_cycle(5'd7);

    // backpressure
    ex_ready = 1'b0; if_valid = 1'b1; if_instr = mk(6'h01, 5'd8, 5'd9);
    rf_rd_data1 = 16'h0100; rf_rd_data2 = 16'h0200;
    mid();
    check("bp_first_ready", {31'd0, if_ready}, 32'd1);
    cyc();
    if_instr = mk(6'h01, 5'd10, 5'd11);
    rf_rd_data1 = 16'h0300; rf_rd_data2 = 16'h0400;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("bp_if_ready", {31'd0, if_ready}, 32'd0);
      check("bp_ex_valid", {31'd0, ex_valid}, 32'd1);
      check("bp_op_a", {16'd0, ex_op_a}, 32'h0100);
      check("bp_dest", {27'd0, ex_dest}, 32'd8);
      check("bp_busy", dut.u_scoreboard.busy_q, 32'h100);
      cyc();
    end
    ex_ready = 1'b1;
    mid();
    check("bp_release", {31'd0, if_ready}, 32'd1);
    cyc();
    if_valid = 1'b0;
    mid();
    check("bp_next_dest", {27'd0, ex_dest}, 32'd10);
    check("bp_next_op_a", {16'd0, ex_op_a}, 32'h0300);
    check("bp_next_op_b", {16'd0, ex_op_b}, 32'h0400);
    check("bp_next_busy", dut.u_scoreboard.busy_q, 32'h500);
    cyc();
    wb_cycle(5'd8);
    wb_cycle(5'd10);

    // store: no register write
    if_valid = 1'b1; if_instr = mk(6'h31, 5'd5, 5'd2); rf_rd_data1 = 16'h0055;
    mid();
    check("st_if_ready", {31'd0, if_ready}, 32'd1);
    cyc();
    if_valid = 1'b0;
    mid();
    check("st_wb_en", {31'd0, ex_wb_en}, 32'd0);
    check("st_opcode", {26'd0, ex_opcode}, 32'h31);
    check("st_op_a", {16'd0, ex_op_a}, 32'h0055);
    check("st_op_b", {16'd0, ex_op_b}, 32'h0002);
    check("st_busy", dut.u_scoreboard.busy_q, 32'h0);

    // WAW on r3
    cyc();
    if_valid = 1'b1; if_instr = mk(6'h01, 5'd3, 5'd0);
    rf_rd_data1 = 16'h0001; rf_rd_data2 = 16'h0002;
    cyc();
    if_instr = mk(6'h01, 5'd3, 5'd12);
    mid();
    check("waw_stall0", {31'd0, if_ready}, 32'd0);
    cyc();
    mid();
    check("waw_stall1", {31'd0, if_ready}, 32'd0);
    cyc();
    wb_en = 1'b1; wb_dest = 5'd3; wb_data = 16'hBEEF;
    mid();
    check("waw_release", {31'd0, if_ready}, 32'd1);
    cyc();
    wb_en = 1'b0; if_valid = 1'b0; ex_ready = 1'b0;
    mid();
    check("waw_op_a", {16'd0, ex_op_a}, 32'hBEEF);
    check("waw_busy", dut.u_scoreboard.busy_q, 32'h8);

    // asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    check("arst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("arst_op_a", {16'd0, ex_op_a}, 32'h0);
    check("arst_opcode", {26'd0, ex_opcode}, 32'h0);
    check("arst_dest", {27'd0, ex_dest}, 32'd0);
    check("arst_wb_en", {31'd0, ex_wb_en}, 32'd0);
    check("arst_busy", dut.u_scoreboard.busy_q, 32'h0);
    cyc();
    rst_n = 1'b1; ex_ready = 1'b1;
    mid();
    check("arst_if_ready", {31'd0, if_ready}, 32'd1);

    // NOP ignores busy rd field
    cyc();
    if_valid = 1'b1; if_instr = mk(6'h01, 5'd4, 5'd4);
    cyc();
    if_instr = mk(6'h00, 5'd4, 5'd4);
    mid();
    check("nop_if_ready", {31'd0, if_ready}, 32'd1);
    cyc();
    if_valid = 1'b0;
    mid();
    check("nop_ex_valid", {31'd0, ex_valid}, 32'd1);
    check("nop_wb_en", {31'd0, ex_wb_en}, 32'd0);
    check("nop_busy", dut.u_scoreboard.busy_q, 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
